// File: rtl/connect4_pkg.sv
// Shared constants, cell/state/direction types and board-geometry helpers
// for the Connect-4 game-state engine.
package connect4_pkg;

  localparam int ROWS      = 6;
  localparam int COLS      = 7;
  localparam int WIN_LEN   = 4;
  localparam int MAX_MOVES = 42;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    P0     = 2'b01,
    P1     = 2'b10,
    HILITE = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    CHECK = 3'd2,
    EVAL  = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Row grows downward, so "down-right" is +1 row and "up-right" is -1 row.
  typedef enum logic [1:0] {
    H    = 2'd0,
    V    = 2'd1,
    D_DR = 2'd2,
    D_UR = 2'd3
  } dir_t;

  function automatic int dir_dr(input dir_t d);
    case (d)
      V, D_DR: return 1;
      D_UR:    return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_dc(input dir_t d);
    return (d == V) ? 0 : 1;
  endfunction

  function automatic logic on_board(input int r, input int c);
    return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
  endfunction

endpackage

// File: rtl/connect4_game_ctrl_run_count.sv
// Combinational run measurement through one placed cell along one direction:
// length of the matching run and its first cell (the end opposite the step).
module connect4_run_count
  import connect4_pkg::*;
(
  input  logic [1:0] panel [0:ROWS-1][0:COLS-1],
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  dir_t       dir,
  input  logic [1:0] code,
  output logic [2:0] run_len,
  output logic [2:0] start_row,
  output logic [2:0] start_col
);

  logic [2:0] fwd_n;
  logic [2:0] bwd_n;
  logic       fwd_go;
  logic       bwd_go;

  // Each side stops at the first off-board or non-matching cell.
  always_comb begin
    fwd_n  = 3'd0;
    bwd_n  = 3'd0;
    fwd_go = 1'b1;
    bwd_go = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      if (fwd_go &&
          on_board(int'(row) + k * dir_dr(dir), int'(col) + k * dir_dc(dir)) &&
          (panel[3'(int'(row) + k * dir_dr(dir))][3'(int'(col) + k * dir_dc(dir))] == code)) begin
        fwd_n = fwd_n + 3'd1;
      end else begin
        fwd_go = 1'b0;
      end
      if (bwd_go &&
          on_board(int'(row) - k * dir_dr(dir), int'(col) - k * dir_dc(dir)) &&
          (panel[3'(int'(row) - k * dir_dr(dir))][3'(int'(col) - k * dir_dc(dir))] == code)) begin
        bwd_n = bwd_n + 3'd1;
      end else begin
        bwd_go = 1'b0;
      end
    end
  end

  assign run_len   = 3'd1 + fwd_n + bwd_n;
  assign start_row = 3'(int'(row) - int'(bwd_n) * dir_dr(dir));
  assign start_col = 3'(int'(col) - int'(bwd_n) * dir_dc(dir));

endmodule

// File: rtl/connect4_game_ctrl.sv
// Connect-4 game-state engine: cursor, gravity drop, four-direction win check,
// draw detection and winning-line highlight driving the panel/play/turn outputs.
module connect4_game_ctrl
  import connect4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_drop,
  input  logic             new_game,
  output logic [1:0]       panel [0:ROWS-1][0:COLS-1],
  output logic [0:COLS-1]  play,
  output logic             turn,
  output logic [1:0]       winner,
  output logic             busy,
  output logic             col_full,
  output state_t           dbg_state
);

  // Handshake: btn_* are single-cycle pulses accepted only in IDLE; busy is
  // high from the cycle after an accepted drop until the drop is resolved,
  // and any pulse arriving while busy (or in OVER) is dropped, not queued.

  logic [1:0]      panel_q [0:ROWS-1][0:COLS-1];
  logic [1:0]      panel_d [0:ROWS-1][0:COLS-1];
  logic [2:0]      cursor_q, cursor_d;
  logic [0:COLS-1] play_q, play_d;
  logic            turn_q, turn_d;
  logic [1:0]      winner_q, winner_d;
  logic            busy_q, busy_d;
  logic            col_full_q, col_full_d;
  logic [5:0]      moves_q, moves_d;
  state_t          state_q, state_d;
  logic [2:0]      col_q, col_d;
  logic [2:0]      row_q, row_d;
  dir_t            dir_q, dir_d;
  logic            win_found_q, win_found_d;
  dir_t            win_dir_q, win_dir_d;
  logic [2:0]      win_row_q, win_row_d;
  logic [2:0]      win_col_q, win_col_d;
  logic [2:0]      win_len_q, win_len_d;

  logic [1:0]      turn_code;
  logic [2:0]      rc_len;
  logic [2:0]      rc_row;
  logic [2:0]      rc_col;

  assign turn_code = turn_q ? P1 : P0;

  // row_q is the scan index in SCAN and then holds the placed row.
  connect4_run_count u_run_count (
    .panel     (panel_q),
    .row       (row_q),
    .col       (col_q),
    .dir       (dir_q),
    .code      (turn_code),
    .run_len   (rc_len),
    .start_row (rc_row),
    .start_col (rc_col)
  );

  always_comb begin
    panel_d     = panel_q;
    cursor_d    = cursor_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    col_full_d  = 1'b0;
    moves_d     = moves_q;
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dir_d       = dir_q;
    win_found_d = win_found_q;
    win_dir_d   = win_dir_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_len_d   = win_len_q;

    case (state_q)
      IDLE: begin
        if (btn_drop) begin
          col_d   = cursor_q;
          row_d   = 3'(ROWS - 1);
          state_d = SCAN;
        end else if (btn_left && !btn_right) begin
          cursor_d = (cursor_q == 3'd0) ? 3'(COLS - 1) : cursor_q - 3'd1;
        end else if (btn_right && !btn_left) begin
          cursor_d = (cursor_q == 3'(COLS - 1)) ? 3'd0 : cursor_q + 3'd1;
        end
      end

      SCAN: begin
        if (panel_q[row_q][col_q] == EMPTY) begin
          panel_d[row_q][col_q] = turn_code;
          state_d     = CHECK;
          dir_d       = H;
          win_found_d = 1'b0;
        end else if (row_q == 3'd0) begin
          col_full_d = 1'b1;
          state_d    = IDLE;
        end else begin
          row_d = row_q - 3'd1;
        end
      end

      CHECK: begin
        if (!win_found_q && (rc_len >= 3'(WIN_LEN))) begin
          win_found_d = 1'b1;
          win_dir_d   = dir_q;
          win_row_d   = rc_row;
          win_col_d   = rc_col;
          win_len_d   = rc_len;
        end
        if (dir_q == D_UR) begin
          state_d = EVAL;
        end else begin
          dir_d = dir_t'(dir_q + 2'd1);
        end
      end

      EVAL: begin
        moves_d = (moves_q == 6'(MAX_MOVES)) ? moves_q : moves_q + 6'd1;
        if (win_found_q) begin
          winner_d = turn_code;
          for (int k = 0; k < COLS; k++) begin
            if (k < int'(win_len_q)) begin
              panel_d[3'(int'(win_row_q) + k * dir_dr(win_dir_q))]
                     [3'(int'(win_col_q) + k * dir_dc(win_dir_q))] = HILITE;
            end
          end
          state_d = OVER;
        end else if (moves_d == 6'(MAX_MOVES)) begin
          winner_d = HILITE;
          state_d  = OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = IDLE;
        end
      end

      OVER: begin
        state_d = OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SCAN) || (state_d == CHECK) || (state_d == EVAL);
    play_d = '0;
    play_d[cursor_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      panel_q     <= '{default: 2'b00};
      cursor_q    <= 3'd3;
      play_q      <= 7'b0001000;
      turn_q      <= 1'b0;
      winner_q    <= 2'b00;
      busy_q      <= 1'b0;
      col_full_q  <= 1'b0;
      moves_q     <= 6'd0;
      state_q     <= IDLE;
      col_q       <= 3'd0;
      row_q       <= 3'd0;
      dir_q       <= H;
      win_found_q <= 1'b0;
      win_dir_q   <= H;
      win_row_q   <= 3'd0;
      win_col_q   <= 3'd0;
      win_len_q   <= 3'd0;
    end else begin
      panel_q     <= panel_d;
      cursor_q    <= cursor_d;
      play_q      <= play_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      busy_q      <= busy_d;
      col_full_q  <= col_full_d;
      moves_q     <= moves_d;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dir_q       <= dir_d;
      win_found_q <= win_found_d;
      win_dir_q   <= win_dir_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_len_q   <= win_len_d;
    end
  end

  assign panel     = panel_q;
  assign play      = play_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign busy      = busy_q;
  assign col_full  = col_full_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_connect4_game_ctrl.sv
// Directed bench for connect4_game_ctrl: cursor vector table plus hand-written
// game sequences checked against a bench-side board model.
module tb_connect4_game_ctrl;
  import connect4_pkg::*;

  logic            clk;
  logic            rst;
  logic            btn_left;
  logic            btn_right;
  logic            btn_drop;
  logic            new_game;
  logic [1:0]      panel [0:ROWS-1][0:COLS-1];
  logic [0:COLS-1] play;
  logic            turn;
  logic [1:0]      winner;
  logic            busy;
  logic            col_full;
  state_t          dbg_state;

  connect4_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_drop  (btn_drop),
    .new_game  (new_game),
    .panel     (panel),
    .play      (play),
    .turn      (turn),
    .winner    (winner),
    .busy      (busy),
    .col_full  (col_full),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int         checks;
  int         errors;
  logic [1:0] model [0:ROWS-1][0:COLS-1];
  logic       exp_turn;
  int         exp_col;

  typedef struct {
    logic l;
    logic r;
    int   exp_col;
  } cur_vec_t;

  cur_vec_t cur_tab [0:8];
  int       draw_seq [0:41];

  function automatic logic [0:COLS-1] onehot(input int c);
    logic [0:COLS-1] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_panel(input string name);
    int bad;
    bad = 0;
    checks++;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (panel[r][c] !== model[r][c]) begin
          if (bad == 0)
            $display("FAIL %s: cell[%0d][%0d] got %0d expected %0d", name, r, c, panel[r][c], model[r][c]);
          bad++;
        end
      end
    end
    if (bad != 0) errors++;
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = 2'b00;
    exp_turn = 1'b0;
    exp_col  = 3;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic l, input logic r, input logic d);
    @(negedge clk);
    btn_left  = l;
    btn_right = r;
    btn_drop  = d;
    @(negedge clk);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_drop  = 1'b0;
  endtask

  task automatic start_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    clear_model();
  endtask

  task automatic move_to(input int col);
    while (exp_col != col) begin
      pulse(1'b0, 1'b1, 1'b0);
      exp_col = (exp_col + 1) % COLS;
    end
    check("cursor_pos", play, onehot(exp_col));
  endtask

  // Drop into col; landing row from the model, latency 11-r measured on busy.
  task automatic do_drop(input int col, input logic with_left, input logic [1:0] exp_win);
    int r;
    int n;
    move_to(col);
    r = -1;
    for (int i = ROWS - 1; i >= 0; i--)
      if (model[i][col] == 2'b00 && r < 0) r = i;
    pulse(with_left, 1'b0, 1'b1);
    if (with_left) check("drop_beats_left", play, onehot(exp_col));
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("drop_latency", n, 11 - r);
    model[r][col] = exp_turn ? 2'b10 : 2'b01;
    if (exp_win == 2'b00) exp_turn = ~exp_turn;
    check("turn", turn, exp_turn);
    check("winner", winner, exp_win);
    if (exp_win == 2'b00 || exp_win == 2'b11) check_panel("panel_after_drop");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int any_busy;
    int k;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_drop  = 1'b0;
    new_game  = 1'b0;
    clear_model();

    cur_tab[0] = '{l: 1'b1, r: 1'b0, exp_col: 2};
    cur_tab[1] = '{l: 1'b1, r: 1'b0, exp_col: 1};
    cur_tab[2] = '{l: 1'b1, r: 1'b0, exp_col: 0};
    cur_tab[3] = '{l: 1'b1, r: 1'b0, exp_col: 6};
    cur_tab[4] = '{l: 1'b0, r: 1'b1, exp_col: 0};
    cur_tab[5] = '{l: 1'b0, r: 1'b1, exp_col: 1};
    cur_tab[6] = '{l: 1'b1, r: 1'b1, exp_col: 1};
    cur_tab[7] = '{l: 1'b0, r: 1'b1, exp_col: 2};
    cur_tab[8] = '{l: 1'b0, r: 1'b1, exp_col: 3};

    // Draw script: column pairs (A,B) filled a,b,b,a x3, then column 5 alone.
    k = 0;
    for (int p = 0; p < 3; p++) begin
      int a;
      int b;
      a = (p == 0) ? 0 : (p == 1) ? 1 : 4;
      b = (p == 0) ? 2 : (p == 1) ? 3 : 6;
      for (int rep = 0; rep < 3; rep++) begin
        draw_seq[k] = a; draw_seq[k + 1] = b; draw_seq[k + 2] = b; draw_seq[k + 3] = a;
        k = k + 4;
      end
    end
    for (int i = 0; i < 6; i++) draw_seq[36 + i] = 5;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_panel("reset_panel");
    check("reset_play", play, 7'b0001000);
    check("reset_turn", turn, 1'b0);
    check("reset_winner", winner, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_col_full", col_full, 1'b0);
    check("reset_state", dbg_state, IDLE);

    // Cursor vector table
    for (int i = 0; i < 9; i++) begin
      pulse(cur_tab[i].l, cur_tab[i].r, 1'b0);
      exp_col = cur_tab[i].exp_col;
      check("cursor_table", play, onehot(cur_tab[i].exp_col));
      check("cursor_busy", busy, 1'b0);
    end

    // Horizontal win in row 5, cols 2..5, completed by col 4
    start_new_game();
    do_drop(3, 1'b1, 2'b00);
    do_drop(3, 1'b0, 2'b00);
    do_drop(2, 1'b0, 2'b00);
    do_drop(2, 1'b0, 2'b00);
    do_drop(5, 1'b0, 2'b00);
    do_drop(5, 1'b0, 2'b00);
    do_drop(4, 1'b0, 2'b01);
    for (int c = 2; c <= 5; c++) model[5][c] = 2'b11;
    check_panel("hwin_highlight");
    check("hwin_turn_held", turn, 1'b0);
    check("hwin_state", dbg_state, OVER);

    // OVER ignores buttons
    pulse(1'b1, 1'b0, 1'b1);
    any_busy = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0) any_busy = 1;
      @(negedge clk);
    end
    check("over_no_busy", any_busy, 0);
    check("over_cursor", play, onehot(exp_col));
    check("over_winner", winner, 2'b01);
    check_panel("over_panel");

    // Vertical win in column 0, landing row 2
    start_new_game();
    check("newgame_state", dbg_state, IDLE);
    check("newgame_play", play, 7'b0001000);
    for (int i = 0; i < 3; i++) begin
      do_drop(0, 1'b0, 2'b00);
      do_drop(1, 1'b0, 2'b00);
    end
    do_drop(0, 1'b0, 2'b01);
    for (int r = 2; r <= 5; r++) model[r][0] = 2'b11;
    check_panel("vwin_highlight");

    // Full column 4
    start_new_game();
    for (int i = 0; i < 6; i++) do_drop(4, 1'b0, 2'b00);
    pulse(1'b0, 1'b0, 1'b1);
    check("full_busy_start", busy, 1'b1);
    repeat (5) @(negedge clk);
    check("full_pulse_early", col_full, 1'b0);
    @(negedge clk);
    check("full_pulse", col_full, 1'b1);
    @(negedge clk);
    check("full_pulse_end", col_full, 1'b0);
    check("full_busy_end", busy, 1'b0);
    check("full_turn", turn, 1'b0);
    check("full_state", dbg_state, IDLE);
    check_panel("full_panel");

    // new_game while SCAN is walking up column 4
    start_new_game();
    for (int i = 0; i < 3; i++) do_drop(4, 1'b0, 2'b00);
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("midscan_busy", busy, 1'b1);
    new_game = 1'b1;
    @(negedge clk);
    clear_model();
    check_panel("midscan_clear");
    check("midscan_state", dbg_state, IDLE);
    check("midscan_busy_low", busy, 1'b0);
    check("midscan_play", play, 7'b0001000);
    check("midscan_turn", turn, 1'b0);
    new_game = 1'b0;
    repeat (8) @(negedge clk);
    check_panel("midscan_no_write");
    check("midscan_idle_busy", busy, 1'b0);

    // 42-move draw
    start_new_game();
    for (int i = 0; i < 42; i++) do_drop(draw_seq[i], 1'b0, (i == 41) ? 2'b11 : 2'b00);
    check("draw_state", dbg_state, OVER);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    any_busy = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0) any_busy = 1;
      @(negedge clk);
    end
    check("draw_ignore_busy", any_busy, 0);
    check("draw_winner_held", winner, 2'b11);
    check_panel("draw_panel_held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
